boot_sequencer: RTL
===================

Name: boot_sequencer

Overview:
Synthesisable boot/run controller for pipelined_processor. It keeps the core in reset and streams a program into instruction memory over a valid/ready port. It then holds reset for a programmable number of cycles, releases the core, and watches the fetch PC for a halt address or a cycle budget. It is the in-fabric generalisation of the bench reset/load/run/stop sequence: depth, hold, budget and halt detection are parametrised, and it adds overflow detection and status reporting.

Parameters:
XLEN, 32, instruction/PC width
IMEM_DEPTH, 256, instruction memory words; power of two, >=2
AW, $clog2(IMEM_DEPTH), word address width
HOLD_CYCLES, 5, cycles cpu_reset stays high after load completes; >=1
MAX_RUN, 1000, run-cycle budget before timeout; >=1

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a load/run sequence (sampled only in IDLE, DONE, ERR)
halt_pc  in  XLEN  PC value that marks program end; sampled on start
ld_valid  in  1  load word valid
ld_ready  out  1  load word accepted when ld_valid&ld_ready
ld_data  in  XLEN  instruction word
ld_last  in  1  marks the final word of the program
imem_we  out  1  instruction memory write enable
imem_addr  out  AW  instruction memory word address
imem_wdata  out  XLEN  instruction memory write data
cpu_reset  out  1  active-high reset to pipelined_processor
pc_f  in  XLEN  processor fetch PC (PCF)
busy  out  1  high in LOAD, HOLD, RUN
done  out  1  halt_pc reached; held until next start
timeout  out  1  MAX_RUN exhausted; held until next start
overflow  out  1  more than IMEM_DEPTH words offered; held until next start
words_loaded  out  AW+1  words written in the current sequence
run_cycles  out  32  cycles spent in RUN

Behaviour:
- States: IDLE, LOAD, HOLD, RUN, DONE, ERR. Encoded in the shared package.
- Reset (reset=0, async): state=IDLE, cpu_reset=1, ld_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, timeout=0, overflow=0, words_loaded=0, run_cycles=0, latched halt_pc=0. Reset mid-sequence aborts immediately; no partial state survives.
- cpu_reset=1 in every state except RUN.
- IDLE/DONE/ERR + start -> LOAD:
  - clears done, timeout, overflow, words_loaded and run_cycles
  - latches halt_pc
  - start in any other state is ignored.
- LOAD:
  - ld_ready=1.
  - On each handshake, the next cycle has imem_we=1, imem_addr=words_loaded[AW-1:0] (pre-increment value), imem_wdata=ld_data. words_loaded increments. Write latency is exactly 1 cycle.
  - Handshake with ld_last=1 -> HOLD, with ld_ready=0 from the next cycle.
  - Handshake while words_loaded==IMEM_DEPTH (memory full) -> no write, overflow=1, go to ERR.
  - ld_last on word number IMEM_DEPTH is legal.
  - ld_valid=0 stalls indefinitely; there is no timeout in LOAD.
- HOLD: a counter runs for exactly HOLD_CYCLES cycles, then RUN. cpu_reset falls on the first RUN cycle.
- RUN:
  - run_cycles increments every cycle and saturates at 2^32-1.
  - Each cycle, pc_f==latched halt_pc -> DONE, done=1.
  - Otherwise, when run_cycles reaches MAX_RUN-1 -> ERR, timeout=1.
  - If both conditions occur in the same cycle, halt wins (done=1, timeout=0).
  - pc_f is ignored in all other states.
- ERR and DONE hold cpu_reset=1 and freeze the status outputs.
- Zero-word program is impossible: LOAD always needs at least one handshake.
- All outputs are registered. No combinational path from inputs to outputs except ld_ready, which is state-decoded only.

Decomposition:
- Package boot_seq_pkg:
  - state enum
  - localparams for default HOLD_CYCLES and MAX_RUN
  - width function for AW
- One sub-module, seq_counter: parametrised-width down-counter with load, enable and zero flag. It is instantiated twice, once for HOLD and once for the RUN budget.
- The run_cycles status counter stays inline.

Test Plan:
- Load 5 words (0x00000013, 0x01000093, 0x00800113, 0x00A00213, 0x00000193), last on the 5th, HOLD_CYCLES=5, halt_pc=0x10. Required: imem writes at addr 0..4 with matching data; cpu_reset stays high 5 cycles after load; PC model reaches 0x10 -> done=1, words_loaded=5, cpu_reset=1.
- Same program with halt_pc=0xFFFC and MAX_RUN=20 -> timeout=1 after exactly 20 RUN cycles, run_cycles=20, done=0.
- IMEM_DEPTH=4; offer 5 words with no ld_last -> 4 writes (addr 0..3), then overflow=1, state ERR, no 5th write.
- ld_valid toggled 1/0 every other cycle during a 3-word load -> exactly 3 writes at addr 0,1,2; no duplicates.
- reset=0 asserted mid-RUN (cycle 7) -> all outputs return to reset values asynchronously; a new start loads again from addr 0.
- pc_f equals halt_pc on the same cycle the budget expires -> done=1, timeout=0. A start pulse issued during RUN is ignored.

Source files
------------

// File: rtl/boot_sequencer_pkg.sv
// Shared types and helpers for the boot/run controller of pipelined_processor.
package boot_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_DONE,
    S_ERR
  } state_e;

  localparam int DEF_HOLD_CYCLES = 5;
  localparam int DEF_MAX_RUN     = 1000;

  // Bits needed to hold 0..n-1, never narrower than one bit.
  function automatic int addr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/boot_sequencer_if.sv
// Program-load stream: a valid/ready word channel with an end-of-program marker.
interface boot_sequencer_if #(
  parameter int XLEN = 32
);
  logic            ld_valid;
  logic            ld_ready;
  logic [XLEN-1:0] ld_data;
  logic            ld_last;

  modport master (output ld_valid, output ld_data, output ld_last, input ld_ready);
  modport slave  (input ld_valid, input ld_data, input ld_last, output ld_ready);
endinterface

// File: rtl/boot_sequencer_seq_counter.sv
// Loadable down-counter that stops at zero; zero flag is decoded from the register.
module seq_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/boot_sequencer.sv
// Boot/run controller: loads a program into instruction memory, holds the core in
// reset, releases it and watches the fetch PC for a halt address or a cycle budget.
module boot_sequencer
  import boot_seq_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int IMEM_DEPTH  = 256,
  parameter int AW          = addr_width(IMEM_DEPTH),
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int MAX_RUN     = DEF_MAX_RUN
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [XLEN-1:0]      halt_pc,
  boot_sequencer_if.slave      ld,
  output logic                 imem_we,
  output logic [AW-1:0]        imem_addr,
  output logic [XLEN-1:0]      imem_wdata,
  output logic                 cpu_reset,
  input  logic [XLEN-1:0]      pc_f,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic                 overflow,
  output logic [AW:0]          words_loaded,
  output logic [31:0]          run_cycles
);

  localparam int HOLD_W = addr_width(HOLD_CYCLES);
  localparam int RUN_W  = addr_width(MAX_RUN);
  localparam logic [AW:0]     FULL_WORDS = (AW+1)'(IMEM_DEPTH);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [RUN_W-1:0]  RUN_LOAD  = RUN_W'(MAX_RUN - 1);

  state_e state_q, state_d;
  logic            imem_we_q, imem_we_d;
  logic [AW-1:0]   imem_addr_q, imem_addr_d;
  logic [XLEN-1:0] imem_wdata_q, imem_wdata_d;
  logic            cpu_reset_q, cpu_reset_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            timeout_q, timeout_d;
  logic            overflow_q, overflow_d;
  logic [AW:0]     words_q, words_d;
  logic [31:0]     run_q, run_d;
  logic [XLEN-1:0] halt_q, halt_d;
  logic            hold_zero;
  logic            budget_zero;
  logic            load_hs;

  // Both counters reload while their phase is inactive, so entry always starts fresh.
  seq_counter #(.WIDTH(HOLD_W)) u_hold_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .load     (state_q != S_HOLD),
    .load_val (HOLD_LOAD),
    .en       (state_q == S_HOLD),
    .zero     (hold_zero)
  );

  seq_counter #(.WIDTH(RUN_W)) u_budget_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .load     (state_q != S_RUN),
    .load_val (RUN_LOAD),
    .en       (state_q == S_RUN),
    .zero     (budget_zero)
  );

  assign ld.ld_ready = (state_q == S_LOAD);
  assign load_hs     = ld.ld_valid && (state_q == S_LOAD);

  always_comb begin
    state_d      = state_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    done_d       = done_q;
    timeout_d    = timeout_q;
    overflow_d   = overflow_q;
    words_d      = words_q;
    run_d        = run_q;
    halt_d       = halt_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LOAD;
          done_d     = 1'b0;
          timeout_d  = 1'b0;
          overflow_d = 1'b0;
          words_d    = '0;
          run_d      = '0;
          halt_d     = halt_pc;
        end
      end
      S_LOAD: begin
        if (load_hs) begin
          if (words_q == FULL_WORDS) begin
            overflow_d = 1'b1;
            state_d    = S_ERR;
          end else begin
            imem_we_d    = 1'b1;
            imem_addr_d  = words_q[AW-1:0];
            imem_wdata_d = ld.ld_data;
            words_d      = words_q + (AW+1)'(1);
            if (ld.ld_last) begin
              state_d = S_HOLD;
            end
          end
        end
      end
      S_HOLD: begin
        if (hold_zero) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (run_q != '1) begin
          run_d = run_q + 32'd1;
        end
        // Halt takes priority over a budget expiring in the same cycle.
        if (pc_f == halt_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (budget_zero) begin
          state_d   = S_ERR;
          timeout_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cpu_reset_d = (state_d != S_RUN);
    busy_d      = (state_d == S_LOAD) || (state_d == S_HOLD) || (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      overflow_q   <= 1'b0;
      words_q      <= '0;
      run_q        <= '0;
      halt_q       <= '0;
    end else begin
      state_q      <= state_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      overflow_q   <= overflow_d;
      words_q      <= words_d;
      run_q        <= run_d;
      halt_q       <= halt_d;
    end
  end

  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign cpu_reset    = cpu_reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign overflow     = overflow_q;
  assign words_loaded = words_q;
  assign run_cycles   = run_q;

endmodule
